ysyx_23060203_axi_rd_sram: RTL and testbench

//  AXI4 read-channel responder backed by a word-addressed memory array; serves SINGLE/INCR/WRAP bursts.
//  Far end of the instruction-fetch refill path: the I-cache issues wrap bursts, this block returns the beats.

---
 rtl/ysyx_23060203_axi_pkg.sv | 7 +
 rtl/ysyx_23060203_axi_addr_gen.sv | 25 ++
 rtl/ysyx_23060203_axi_rd_sram.sv | 112 +++++++++++
 tb/tb_ysyx_23060203_axi_rd_sram.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060203_axi_pkg.sv
// ysyx_23060203_axi_pkg: AXI burst/response encodings and read-responder states shared by the initiators and responders
package ysyx_23060203_axi_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, BEAT} rd_state_t;
endpackage

// File: rtl/ysyx_23060203_axi_addr_gen.sv
// ysyx_23060203_axi_addr_gen: combinational AXI next-beat address and WRAP legality check
//   addr/size/len/burst : current beat address and burst attributes
//   next_addr           : address of the following beat (modulo 2^ADDR_W)
//   wrap_err            : WRAP burst with illegal length or a start address not aligned to the beat size
module ysyx_23060203_axi_addr_gen
  import ysyx_23060203_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              wrap_err
);
  logic [ADDR_W-1:0] step, mask, inc;
  always_comb begin
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) * step) - ADDR_W'(1);
    inc = addr + step;
    next_addr = burst == FIXED ? addr : burst == WRAP ? (addr & ~mask) | (inc & mask) : inc;
    wrap_err = burst == WRAP && (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) || (addr & (step - ADDR_W'(1))) != '0);
  end
endmodule

// File: rtl/ysyx_23060203_axi_rd_sram.sv
// ysyx_23060203_axi_rd_sram: AXI4 read responder over a word-addressed memory (FIXED/INCR/WRAP, single outstanding)
//   clock, reset          : clock, synchronous active-low reset
//   ar*                   : read address channel (arready high only in IDLE)
//   r*                    : read data channel, one beat per rvalid&rready
//   pl_wen/waddr/wdata    : preload port, writes accepted in every state including reset
module ysyx_23060203_axi_rd_sram
  import ysyx_23060203_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH_W = 16,
  parameter logic [ADDR_W-1:0] BASE = ADDR_W'(32'h8000_0000),
  parameter int LAT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arvalid,
  output logic               arready,
  input  logic [ADDR_W-1:0]  araddr,
  input  logic [3:0]         arid,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  output logic               rvalid,
  input  logic               rready,
  output logic [31:0]        rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic [3:0]         rid,
  input  logic               pl_wen,
  input  logic [DEPTH_W-1:0] pl_waddr,
  input  logic [31:0]        pl_wdata
);
  logic [31:0] mem [2**DEPTH_W];
  rd_state_t state, state_n;
  logic [ADDR_W-1:0] addr_q, g_addr, nxt, load_addr, off;
  logic [2:0] size_q, g_size;
  logic [7:0] len_q, g_len, bcnt, lcnt;
  logic [1:0] burst_q, g_burst, rresp_q;
  logic [3:0] id_q;
  logic [31:0] word_q;
  logic err_q, rlast_q, wrap_err, req_err, oor, load, load_err, load_last, idle, ar_hs, r_hs;
  logic [DEPTH_W-1:0] idx;
  // In IDLE the generator sees the incoming request (legality check, LAT=0 first beat);
  // afterwards it steps the latched burst.
  ysyx_23060203_axi_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr(g_addr), .size(g_size), .len(g_len), .burst(g_burst), .next_addr(nxt), .wrap_err(wrap_err)
  );
  always_comb begin
    idle = state == IDLE;
    arready = reset && idle;
    rvalid = state == BEAT;
    ar_hs = arvalid && arready;
    r_hs = rvalid && rready;
    g_addr = idle ? araddr : addr_q;
    g_size = idle ? arsize : size_q;
    g_len = idle ? arlen : len_q;
    g_burst = idle ? arburst : burst_q;
    req_err = g_size > 3'd2 || g_burst == RSVD || wrap_err;
    state_n = idle ? (ar_hs ? (LAT == 0 ? BEAT : WAIT) : IDLE)
            : state == WAIT ? (lcnt == 8'(LAT - 1) ? BEAT : WAIT)
            : (r_hs && rlast_q ? IDLE : BEAT);
    // A beat register is loaded on the edge that presents a new beat: entry to BEAT or an accepted non-final beat.
    load = reset && state_n == BEAT && (state != BEAT || r_hs);
    load_addr = idle ? araddr : state == BEAT ? nxt : addr_q;
    off = load_addr - BASE;
    oor = |(off >> (DEPTH_W + 2));
    idx = off[DEPTH_W+1:2];
    load_err = (idle ? req_err : err_q) || oor;
    load_last = ((state == BEAT) ? bcnt + 8'd1 : 8'd0) == g_len;
    rdata = (rvalid && rresp_q == RESP_OKAY) ? word_q : 32'd0;
    rresp = rvalid ? rresp_q : RESP_OKAY;
    rlast = rvalid && rlast_q;
    rid = id_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
      id_q <= 4'd0;
      bcnt <= 8'd0;
      lcnt <= 8'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == WAIT) lcnt <= lcnt + 8'd1;
      if (ar_hs) begin
        addr_q <= araddr;
        size_q <= arsize;
        len_q <= arlen;
        burst_q <= arburst;
        id_q <= arid;
        err_q <= req_err;
        bcnt <= 8'd0;
        lcnt <= 8'd0;
      end
      if (r_hs) begin
        bcnt <= bcnt + 8'd1;
        addr_q <= nxt;
      end
      if (load) begin
        rresp_q <= load_err ? RESP_SLVERR : RESP_OKAY;
        rlast_q <= load_last;
      end
    end
  end
  // Read and preload share one edge, so a same-cycle read sees the old word.
  always_ff @(posedge clock) begin
    if (pl_wen) mem[pl_waddr] <= pl_wdata;
    if (load) word_q <= mem[idx];
  end
endmodule

// File: tb/tb_ysyx_23060203_axi_rd_sram.sv
// tb_ysyx_23060203_axi_rd_sram: directed bench for the AXI read responder
module tb_ysyx_23060203_axi_rd_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int LAT = 2;
  localparam int DEPTH_W = 16;
  logic clock = 1'b0, reset = 1'b0;
  logic arvalid = 1'b0, arready, rvalid, rready = 1'b0, rlast, pl_wen = 1'b0;
  logic [31:0] araddr = '0, rdata, pl_wdata = '0;
  logic [3:0] arid = '0, rid;
  logic [7:0] arlen = '0;
  logic [2:0] arsize = '0;
  logic [1:0] arburst = '0, rresp;
  logic [DEPTH_W-1:0] pl_waddr = '0;
  int n_chk = 0, n_err = 0, cyc = 0, hs_cyc = 0, nb = 0, lat_obs = -1;
  logic [31:0] bd [32];
  logic [1:0] br [32];
  logic bl [32];
  logic [3:0] bi [32];
  ysyx_23060203_axi_rd_sram #(.ADDR_W(32), .DEPTH_W(DEPTH_W), .BASE(BASE), .LAT(LAT)) dut (
    .clock(clock), .reset(reset), .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rid(rid), .pl_wen(pl_wen), .pl_waddr(pl_waddr), .pl_wdata(pl_wdata)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic logic [31:0] pw(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic preload(input int i, input logic [31:0] d);
    @(negedge clock);
    pl_wen = 1'b1;
    pl_waddr = DEPTH_W'(i);
    pl_wdata = d;
    @(posedge clock);
    #1 pl_wen = 1'b0;
  endtask
  task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    @(negedge clock);
    araddr = a;
    arid = id;
    arlen = len;
    arsize = sz;
    arburst = bu;
    arvalid = 1'b1;
    chk("ar_ready", 32'(arready), 32'd1);
    @(posedge clock);
    #1 hs_cyc = cyc;
    arvalid = 1'b0;
    araddr = 32'hDEAD_0000;
    arid = 4'hF;
  endtask
  // pat 0: always ready; pat 1: ready on every third valid cycle (1,0,0,1,...)
  task automatic recv(input int pat);
    int k;
    logic stall, done, hl;
    logic [31:0] hd;
    nb = 0;
    lat_obs = -1;
    k = 0;
    stall = 1'b0;
    done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clock);
      if (rvalid) begin
        if (lat_obs < 0) lat_obs = cyc - hs_cyc;
        if (stall) begin
          chk("hold_data", rdata, hd);
          chk("hold_last", 32'(rlast), 32'(hl));
        end
        rready = pat == 0 || k % 3 == 0;
        k++;
        if (rready && nb < 32) begin
          bd[nb] = rdata;
          br[nb] = rresp;
          bl[nb] = rlast;
          bi[nb] = rid;
          nb++;
          done = rlast;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          hd = rdata;
          hl = rlast;
        end
      end else rready = 1'b0;
    end
    if (!done) chk("r_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 rready = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    for (int i = 0; i < 16; i++) preload(i, pw(i));
    preload(2 ** DEPTH_W - 1, 32'hDEAD_BEEF);
    @(negedge clock);
    chk("rst_arready2", 32'(arready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_arready", 32'(arready), 32'd1);
    // I-cache refill: WRAP 16 beats starting at word 9
    do_ar(BASE + 32'h24, 4'h3, 8'd15, 3'd2, 2'b10);
    recv(0);
    chk("wrap_lat", 32'(lat_obs), 32'(LAT));
    chk("wrap_nb", 32'(nb), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap_data%0d", i), bd[i], pw((9 + i) % 16));
      chk($sformatf("wrap_last%0d", i), 32'(bl[i]), 32'(i == 15));
      chk($sformatf("wrap_resp%0d", i), 32'(br[i]), 32'd0);
      chk($sformatf("wrap_id%0d", i), 32'(bi[i]), 32'h3);
    end
    // backpressure on INCR
    do_ar(BASE, 4'h1, 8'd3, 3'd2, 2'b01);
    recv(1);
    chk("bp_nb", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_data%0d", i), bd[i], pw(i));
      chk($sformatf("bp_last%0d", i), 32'(bl[i]), 32'(i == 3));
    end
    // byte-sized INCR returns whole containing words: addrs 1,2,3,4
    do_ar(BASE + 32'h1, 4'h2, 8'd3, 3'd0, 2'b01);
    recv(0);
    chk("nar_nb", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("nar_data%0d", i), bd[i], i == 3 ? pw(1) : pw(0));
    // crossing the top of memory
    do_ar(BASE + 32'(4 * 2 ** DEPTH_W) - 32'd4, 4'h4, 8'd1, 3'd2, 2'b01);
    recv(0);
    chk("oor_nb", 32'(nb), 32'd2);
    chk("oor_data0", bd[0], 32'hDEAD_BEEF);
    chk("oor_resp0", 32'(br[0]), 32'd0);
    chk("oor_last0", 32'(bl[0]), 32'd0);
    chk("oor_data1", bd[1], 32'd0);
    chk("oor_resp1", 32'(br[1]), 32'd2);
    chk("oor_last1", 32'(bl[1]), 32'd1);
    // illegal WRAP length
    do_ar(BASE, 4'h6, 8'd2, 3'd2, 2'b10);
    recv(0);
    chk("wl_nb", 32'(nb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wl_resp%0d", i), 32'(br[i]), 32'd2);
      chk($sformatf("wl_data%0d", i), bd[i], 32'd0);
    end
    chk("wl_last", 32'(bl[2]), 32'd1);
    @(negedge clock);
    chk("wl_arready", 32'(arready), 32'd1);
    // oversized beat
    do_ar(BASE, 4'h7, 8'd1, 3'd3, 2'b01);
    recv(0);
    chk("sz_nb", 32'(nb), 32'd2);
    for (int i = 0; i < 2; i++) chk($sformatf("sz_resp%0d", i), 32'(br[i]), 32'd2);
    @(negedge clock);
    chk("sz_arready", 32'(arready), 32'd1);
    // single FIXED beat with id echo
    do_ar(BASE + 32'h8, 4'hA, 8'd0, 3'd2, 2'b00);
    recv(0);
    chk("fx1_nb", 32'(nb), 32'd1);
    chk("fx1_data", bd[0], pw(2));
    chk("fx1_last", 32'(bl[0]), 32'd1);
    chk("fx1_id", 32'(bi[0]), 32'hA);
    // FIXED repeats the same word
    do_ar(BASE + 32'hC, 4'hB, 8'd3, 3'd2, 2'b00);
    recv(0);
    chk("fx4_nb", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("fx4_data%0d", i), bd[i], pw(3));
    // reset on the fifth beat of a 16-beat burst
    do_ar(BASE, 4'h5, 8'd15, 3'd2, 2'b10);
    begin
      int k;
      logic hit;
      k = 0;
      hit = 1'b0;
      for (int g = 0; g < 100 && !hit; g++) begin
        @(negedge clock);
        if (rvalid) begin
          if (k == 4) begin
            reset = 1'b0;
            rready = 1'b0;
            hit = 1'b1;
          end else begin
            rready = 1'b1;
            k++;
          end
        end
      end
      chk("ab_reached", 32'(hit), 32'd1);
    end
    @(posedge clock);
    #1 chk("ab_rvalid", 32'(rvalid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("ab_quiet", 32'(rvalid), 32'd0);
    end
    do_ar(BASE + 32'h14, 4'h9, 8'd0, 3'd2, 2'b01);
    recv(0);
    chk("ab_nb", 32'(nb), 32'd1);
    chk("ab_data", bd[0], pw(5));
    chk("ab_last", 32'(bl[0]), 32'd1);
    chk("ab_id", 32'(bi[0]), 32'h9);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
